// File: rtl/r2sdf_bf_stage.sv
// One radix-2 single-delay-feedback FFT stage: butterfly span L = 2^(n-1) with an L-deep
// complex feedback delay line, twiddle rotation on the second half-block and registered outputs.
module r2sdf_bf_stage #(
  parameter int unsigned N  = 3,
  parameter int unsigned n  = 1,
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N*(1<<N)-1:0]          shuffle_idx,
  input  logic [TW*(1<<(n-1))-1:0]     cos_arr,
  input  logic [TW*(1<<(n-1))-1:0]     sin_arr,
  input  logic                         in_valid,
  input  logic signed [DW-1:0]         ip_real,
  input  logic signed [DW-1:0]         ip_img,
  output logic                         out_valid,
  output logic signed [DW:0]           op_real,
  output logic signed [DW:0]           op_img
);

  localparam int unsigned L  = 1 << (n - 1);
  localparam int unsigned CW = n;
  localparam int unsigned OW = DW + 1;
  localparam int unsigned SW = DW + 3;
  localparam int unsigned PW = DW + TW + 2;
  localparam int unsigned FB = TW - 2;
  localparam logic signed [PW-1:0] Rnd = PW'(1) << (FB - 1);

  logic [CW-1:0]        cnt_q;
  logic                 primed_q;
  logic signed [OW-1:0] dl_re_q [L];
  logic signed [OW-1:0] dl_im_q [L];

  logic                 phase_b;
  logic [CW-1:0]        k;
  logic signed [TW-1:0] c, s;
  logic signed [PW-1:0] prod_re, prod_im;
  logic signed [SW-1:0] t_re, t_im, a_re, a_im;
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [OW-1:0] x_re, x_im, push_re, push_im;

  // The index table only documents the input ordering; the datapath does not consume it.
  logic unused_shuffle;
  assign unused_shuffle = ^shuffle_idx;

  function automatic logic signed [OW-1:0] sat(input logic signed [SW-1:0] v);
    if (v[SW-1:OW-1] == {(SW-OW+1){v[SW-1]}}) begin
      return v[OW-1:0];
    end else if (v[SW-1]) begin
      return {1'b1, {(OW-1){1'b0}}};
    end else begin
      return {1'b0, {(OW-1){1'b1}}};
    end
  endfunction

  always_comb begin
    phase_b = cnt_q[CW-1];
    k       = cnt_q - CW'(L);
    c       = '0;
    s       = '0;
    for (int i = 0; i < int'(L); i++) begin
      if (k == CW'(i)) begin
        c = cos_arr[i*TW +: TW];
        s = sin_arr[i*TW +: TW];
      end
    end
    // x * (c - js), rounded half-up before the arithmetic shift
    prod_re = PW'(ip_real) * PW'(c) + PW'(ip_img) * PW'(s) + Rnd;
    prod_im = PW'(ip_img) * PW'(c) - PW'(ip_real) * PW'(s) + Rnd;
    t_re    = SW'(prod_re >>> FB);
    t_im    = SW'(prod_im >>> FB);
    a_re    = SW'(dl_re_q[0]);
    a_im    = SW'(dl_im_q[0]);
    sum_re  = a_re + t_re;
    sum_im  = a_im + t_im;
    dif_re  = a_re - t_re;
    dif_im  = a_im - t_im;
    x_re    = OW'(ip_real);
    x_im    = OW'(ip_img);
    push_re = phase_b ? sat(dif_re) : x_re;
    push_im = phase_b ? sat(dif_im) : x_im;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      out_valid <= 1'b0;
      op_real   <= '0;
      op_img    <= '0;
      for (int i = 0; i < int'(L); i++) begin
        dl_re_q[i] <= '0;
        dl_im_q[i] <= '0;
      end
    end else if (in_valid) begin
      cnt_q <= cnt_q + CW'(1);
      for (int i = 0; i < int'(L) - 1; i++) begin
        dl_re_q[i] <= dl_re_q[i+1];
        dl_im_q[i] <= dl_im_q[i+1];
      end
      dl_re_q[L-1] <= push_re;
      dl_im_q[L-1] <= push_im;
      if (phase_b) begin
        primed_q <= 1'b1;
      end
      // Phase A drains the previous block's differences; only meaningful once primed.
      out_valid <= phase_b | primed_q;
      op_real   <= phase_b ? sat(sum_re) : dl_re_q[0];
      op_img    <= phase_b ? sat(sum_im) : dl_im_q[0];
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Directed bench for r2sdf_bf_stage: a stage-1 and a stage-2 instance of an 8-point transform,
// checked against hand-computed butterfly results.
module tb_r2sdf_bf_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [23:0] shuf;
  logic [15:0] cos1, sin1;
  logic [31:0] cos2, sin2;
  logic v1, v2;
  logic signed [15:0] r1, i1, r2, i2;
  logic ov1, ov2;
  logic signed [16:0] or1, oi1, or2, oi2;

  int checks = 0;
  int failures = 0;

  int t1_in  [9] = '{0, 10, 2, 3, 1, 3, 21, 31, 0};
  int t1_exp [8] = '{10, -10, 5, -1, 4, -2, 52, -10};
  int t2_in  [6] = '{1, 2, 3, 4, 0, 0};
  int t2_re  [4] = '{4, 2, -2, 2};
  int t2_im  [4] = '{0, -4, 0, 4};

  always #5 clk = ~clk;

  r2sdf_bf_stage #(.N(3), .n(1), .DW(16), .TW(16)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .shuffle_idx(shuf),
    .cos_arr    (cos1),
    .sin_arr    (sin1),
    .in_valid   (v1),
    .ip_real    (r1),
    .ip_img     (i1),
    .out_valid  (ov1),
    .op_real    (or1),
    .op_img     (oi1)
  );

  r2sdf_bf_stage #(.N(3), .n(2), .DW(16), .TW(16)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .shuffle_idx(shuf),
    .cos_arr    (cos2),
    .sin_arr    (sin2),
    .in_valid   (v2),
    .ip_real    (r2),
    .ip_img     (i2),
    .out_valid  (ov2),
    .op_real    (or2),
    .op_img     (oi2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat1(input logic v, input int r, input int i);
    v1 = v;
    r1 = 16'(r);
    i1 = 16'(i);
    @(negedge clk);
  endtask

  task automatic beat2(input logic v, input int r, input int i);
    v2 = v;
    r2 = 16'(r);
    i2 = 16'(i);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v1 = 1'b0; r1 = '0; i1 = '0;
    v2 = 1'b0; r2 = '0; i2 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_t1(input string tag);
    for (int j = 0; j < 9; j++) begin
      beat1(1'b1, t1_in[j], 0);
      if (j == 0) begin
        chk({tag, "_first_valid"}, 32'(ov1), 0);
      end else begin
        chk({tag, "_valid"}, 32'(ov1), 1);
        chk({tag, "_re"}, 32'(or1), t1_exp[j-1]);
        chk({tag, "_im"}, 32'(oi1), 0);
      end
    end
  endtask

  initial begin
    logic [2:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 3'(i);
      shuf[i*3 +: 3] = {b[0], b[1], b[2]};
    end
    cos1 = 16'd16384;
    sin1 = 16'd0;
    cos2 = {16'd0, 16'd16384};
    sin2 = {16'd16384, 16'd0};

    // Reset state
    do_reset();
    chk("rst_valid1", 32'(ov1), 0);
    chk("rst_re1", 32'(or1), 0);
    chk("rst_im1", 32'(oi1), 0);
    chk("rst_valid2", 32'(ov2), 0);
    chk("rst_re2", 32'(or2), 0);

    // Stage 1, continuous real input
    run_t1("t1");
    beat1(1'b0, 5, 5);
    chk("t1_idle_valid", 32'(ov1), 0);
    chk("t1_idle_hold", 32'(or1), -10);

    // Mid-frame reset, then full restart
    do_reset();
    beat1(1'b1, t1_in[0], 0);
    beat1(1'b1, t1_in[1], 0);
    beat1(1'b1, t1_in[2], 0);
    chk("t5_pre_re", 32'(or1), -10);
    rst_n = 1'b0;
    beat1(1'b1, 7, 7);
    rst_n = 1'b1;
    chk("t5_rst_valid", 32'(ov1), 0);
    chk("t5_rst_re", 32'(or1), 0);
    chk("t5_rst_im", 32'(oi1), 0);
    run_t1("t5");

    // Stage 2, continuous, W^1 = -j
    do_reset();
    for (int j = 0; j < 6; j++) begin
      beat2(1'b1, t2_in[j], 0);
      if (j < 2) begin
        chk("t2_early_valid", 32'(ov2), 0);
      end else begin
        chk("t2_valid", 32'(ov2), 1);
        chk("t2_re", 32'(or2), t2_re[j-2]);
        chk("t2_im", 32'(oi2), t2_im[j-2]);
      end
    end

    // Stage 2, in_valid toggling
    do_reset();
    for (int j = 0; j < 6; j++) begin
      beat2(1'b1, t2_in[j], 0);
      if (j < 2) begin
        chk("t3_early_valid", 32'(ov2), 0);
      end else begin
        chk("t3_valid", 32'(ov2), 1);
        chk("t3_re", 32'(or2), t2_re[j-2]);
        chk("t3_im", 32'(oi2), t2_im[j-2]);
      end
      beat2(1'b0, 99, 99);
      chk("t3_gap_valid", 32'(ov2), 0);
      if (j >= 2) begin
        chk("t3_gap_hold", 32'(or2), t2_re[j-2]);
      end
    end

    // Stage 2, W^1 = (1-j)/sqrt2, positive saturation
    cos2 = {16'd11585, 16'd16384};
    sin2 = {16'd11585, 16'd0};
    do_reset();
    beat2(1'b1, 0, 0);
    chk("t4_s0_valid", 32'(ov2), 0);
    beat2(1'b1, 32767, 0);
    chk("t4_s1_valid", 32'(ov2), 0);
    beat2(1'b1, 0, 0);
    chk("t4_k0_valid", 32'(ov2), 1);
    chk("t4_k0_re", 32'(or2), 0);
    chk("t4_k0_im", 32'(oi2), 0);
    beat2(1'b1, 32767, 32767);
    chk("t4_k1_re_sat", 32'(or2), 65535);
    chk("t4_k1_im", 32'(oi2), 0);
    beat2(1'b1, 0, 0);
    chk("t4_d0_re", 32'(or2), 0);
    beat2(1'b1, 0, 0);
    chk("t4_d1_valid", 32'(ov2), 1);
    chk("t4_d1_re", 32'(or2), -13572);
    chk("t4_d1_im", 32'(oi2), 0);

    // Stage 1 extreme difference stays in range
    do_reset();
    beat1(1'b1, -32768, 0);
    chk("t6a_s0_valid", 32'(ov1), 0);
    beat1(1'b1, 32767, 0);
    chk("t6a_sum", 32'(or1), -1);
    beat1(1'b1, 0, 0);
    chk("t6a_diff_valid", 32'(ov1), 1);
    chk("t6a_diff", 32'(or1), -65535);

    // Stage 2 mirrored case, negative saturation
    do_reset();
    beat2(1'b1, 0, 0);
    beat2(1'b1, -32768, 0);
    beat2(1'b1, 0, 0);
    chk("t6b_k0_re", 32'(or2), 0);
    beat2(1'b1, -32768, -32768);
    chk("t6b_k1_re_sat", 32'(or2), -65536);
    chk("t6b_k1_im", 32'(oi2), 0);
    beat2(1'b1, 0, 0);
    chk("t6b_d0_re", 32'(or2), 0);
    beat2(1'b1, 0, 0);
    chk("t6b_d1_re", 32'(or2), 13572);
    chk("t6b_d1_im", 32'(oi2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
